// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and write-port priority helpers for regfile_mp
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int unsigned R0_ADDR = 0;

  // Helpers take write ports zero-extended to these maxima so one function serves every instance.
  localparam int MAX_WPORTS = 8;
  localparam int MAX_ADDR_W = 16;
  localparam int PORT_W     = 3;

  typedef struct packed {
    logic              hit;
    logic [PORT_W-1:0] port;
  } wr_sel_t;

  function automatic wr_sel_t wr_select(
    input logic [MAX_WPORTS-1:0]            we,
    input logic [MAX_WPORTS*MAX_ADDR_W-1:0] waddr,
    input logic [MAX_ADDR_W-1:0]            addr
  );
    wr_sel_t sel;
    sel = '0;
    for (int j = 0; j < MAX_WPORTS; j++) begin
      if (we[j] && addr != MAX_ADDR_W'(R0_ADDR) &&
          waddr[j*MAX_ADDR_W +: MAX_ADDR_W] == addr) begin
        sel.hit  = 1'b1;
        sel.port = PORT_W'(j);
      end
    end
    return sel;
  endfunction

  function automatic logic wr_hit(
    input logic [MAX_WPORTS-1:0]            we,
    input logic [MAX_WPORTS*MAX_ADDR_W-1:0] waddr,
    input logic [MAX_ADDR_W-1:0]            addr
  );
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < MAX_WPORTS; j++) begin
      if (we[j] && addr != MAX_ADDR_W'(R0_ADDR) &&
          waddr[j*MAX_ADDR_W +: MAX_ADDR_W] == addr) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy scoreboard: issue sets, writeback clears, per-read-port busy lookup
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NREAD  = 4,
  parameter int NWRITE = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NWRITE-1:0]        we,
  input  logic [NWRITE*ADDR_W-1:0] waddr,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [NREAD*ADDR_W-1:0]  raddr,
  output logic [NREAD-1:0]         rbusy,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0]                   busy_q;
  logic [DEPTH-1:0]                   busy_d;
  logic [MAX_WPORTS-1:0]              we_ext;
  logic [MAX_WPORTS*MAX_ADDR_W-1:0]   waddr_ext;

  always_comb begin
    we_ext    = '0;
    waddr_ext = '0;
    for (int j = 0; j < NWRITE; j++) begin
      we_ext[j]                               = we[j];
      waddr_ext[j*MAX_ADDR_W +: MAX_ADDR_W]   = MAX_ADDR_W'(waddr[j*ADDR_W +: ADDR_W]);
    end
  end

  // Set beats clear: a new producer supersedes the one whose writeback is landing.
  always_comb begin
    logic set;
    logic clr;
    busy_d = '0;
    for (int r = 1; r < DEPTH; r++) begin
      set       = iss_valid && (iss_addr == ADDR_W'(r));
      clr       = wr_hit(we_ext, waddr_ext, MAX_ADDR_W'(r));
      busy_d[r] = set | (busy_q[r] & ~clr);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    logic              hit;
    rbusy = '0;
    for (int i = 0; i < NREAD; i++) begin
      a        = raddr[i*ADDR_W +: ADDR_W];
      hit      = wr_hit(we_ext, waddr_ext, MAX_ADDR_W'(a));
      rbusy[i] = (a != ADDR_W'(R0_ADDR)) && busy_q[a] && !((BYPASS != 0) && hit);
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write-to-read bypass and busy scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NREAD  = 4,
  parameter int NWRITE = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREAD*ADDR_W-1:0]  raddr,
  output logic [NREAD*DATA_W-1:0]  rdata,
  output logic [NREAD-1:0]         rbusy,
  input  logic [NWRITE-1:0]        we,
  input  logic [NWRITE*ADDR_W-1:0] waddr,
  input  logic [NWRITE*DATA_W-1:0] wdata,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]                mem [DEPTH];
  logic [DATA_W-1:0]                wdata_arr [NWRITE];
  logic [DATA_W-1:0]                wr_val [DEPTH];
  logic [DEPTH-1:0]                 wr_hit_v;
  logic [MAX_WPORTS-1:0]            we_ext;
  logic [MAX_WPORTS*MAX_ADDR_W-1:0] waddr_ext;

  always_comb begin
    we_ext    = '0;
    waddr_ext = '0;
    for (int j = 0; j < NWRITE; j++) begin
      we_ext[j]                             = we[j];
      waddr_ext[j*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(waddr[j*ADDR_W +: ADDR_W]);
      wdata_arr[j]                          = wdata[j*DATA_W +: DATA_W];
    end
  end

  // Winning write per register; reused by both storage update and the bypass path.
  always_comb begin
    wr_sel_t sel;
    for (int r = 0; r < DEPTH; r++) begin
      sel         = wr_select(we_ext, waddr_ext, MAX_ADDR_W'(r));
      wr_hit_v[r] = sel.hit;
      wr_val[r]   = '0;
      for (int j = 0; j < NWRITE; j++) begin
        if (sel.port == PORT_W'(j)) wr_val[r] = wdata_arr[j];
      end
    end
  end

  // r0 never sees a hit, so it holds its reset value of zero.
  for (genvar r = 0; r < DEPTH; r++) begin : g_reg
    always_ff @(posedge clk or posedge reset) begin
      if (reset)            mem[r] <= '0;
      else if (wr_hit_v[r]) mem[r] <= wr_val[r];
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] val;
    rdata = '0;
    for (int i = 0; i < NREAD; i++) begin
      a   = raddr[i*ADDR_W +: ADDR_W];
      val = mem[a];
      if ((BYPASS != 0) && wr_hit_v[a]) val = wr_val[a];
      if (reset || a == ADDR_W'(R0_ADDR)) val = '0;
      rdata[i*DATA_W +: DATA_W] = val;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREAD  (NREAD),
    .NWRITE (NWRITE),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .waddr     (waddr),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .raddr     (raddr),
    .rbusy     (rbusy),
    .busy_vec  (busy_vec)
  );

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the dual-issue pipeline.
- Provides NREAD combinational read ports and NWRITE write ports, with optional same-cycle write-to-read bypass.
- Includes an integrated busy scoreboard: a register is marked busy when a producer issues and cleared when its writeback lands.
- Sits between decode (reads, issue) and writeback (writes); register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- NREAD, 4, number of read ports.
- NWRITE, 2, number of write ports; port index is priority, highest index wins.
- BYPASS, 1, 1 = write data forwarded to same-cycle reads; 0 = reads see the registered value only.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears registers and scoreboard.
- raddr  in  NREAD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rdata  out  NREAD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W].
- rbusy  out  NREAD  read port i targets a register with an outstanding producer.
- we  in  NWRITE  per-port write enable, high valid.
- waddr  in  NWRITE*ADDR_W  write addresses.
- wdata  in  NWRITE*DATA_W  write data.
- iss_valid  in  1  a producer issues this cycle; marks iss_addr busy.
- iss_addr  in  ADDR_W  destination register of the issuing producer.
- busy_vec  out  2**ADDR_W  registered scoreboard, bit r = register r busy.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high (reset). While reset is high, all registers = 0, busy_vec = 0, rdata = 0, rbusy = 0.
- Write: at the clk edge, each port j with we[j]=1 and waddr_j!=0 writes wdata_j. Writes to r0 are discarded.
- Write conflict: if several ports write the same address in one cycle, the highest-index port's data is stored.
- Read is combinational, with zero cycles latency.
  - raddr_i==0 → rdata_i = 0 always.
  - BYPASS=1: if any we[j] hits raddr_i (nonzero), rdata_i = wdata of the highest-index hitting port. Otherwise rdata_i = stored value.
  - BYPASS=0: rdata_i = stored value; new data is visible the cycle after the edge.
- Scoreboard, next-state per register r≠0:
  - set = iss_valid & iss_addr==r;
  - clr = any we[j] & waddr_j==r;
  - busy_next = set | (busy & ~clr).
  - Set wins over a simultaneous clear: a new producer supersedes the completing one.
- Scoreboard, other rules:
  - busy_vec[0] is constant 0; iss_addr==0 is ignored.
  - Clearing an already-idle register is a no-op.
  - Re-issuing to a busy register keeps it busy.
- rbusy_i:
  - 0 if raddr_i==0.
  - Otherwise busy_vec[raddr_i] & ~(BYPASS & write hit on raddr_i this cycle).
  - A same-cycle iss_valid does not affect rbusy until the next cycle.
- Reset asserted mid-operation: immediate clear. Writes and issues presented during reset are lost.
- No X propagation: all outputs are defined for all inputs once reset has been applied.

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_W and ADDR_W constants;
  - the R0 address constant;
  - a function for highest-priority write-port selection per address.
- Natural sub-module: regfile_scoreboard (busy_vec state, set/clear logic, rbusy lookup).
- The storage array and bypass muxing stay in regfile_mp.

Test Plan:
- Reset, then read all 32 addresses on 4 ports → rdata=0, rbusy=0, busy_vec=0.
- Write port0 r5=0xDEADBEEF; same cycle read r5 → 0xDEADBEEF with BYPASS=1; old value 0 with BYPASS=0, then 0xDEADBEEF the next cycle.
- Ports 0 and 1 both write r7 (0x11111111, 0x22222222) → next cycle r7=0x22222222. Both write r0 → r0 still reads 0.
- iss r9, cycle N → busy_vec[9]=1 at N+1. Write r9 at N+3 → rbusy for r9 is 0 that cycle with BYPASS=1, and busy_vec[9]=0 at N+4.
- Same cycle iss r12 and write r12 → busy_vec[12]=1 next cycle; iss r0 → busy_vec[0] stays 0.
- Write r3=0xA5A5A5A5 and iss r4, then assert reset asynchronously between edges → r3 reads 0 and busy_vec=0 immediately, without waiting for a clock edge.
